// File: rtl/sysmon_pkg.sv
// sysmon_pkg: shared register map, state encoding and small helpers for the
// thermal fan controller that sits beside rv_sysmon.
package sysmon_pkg;

  // Register byte offsets on the peripheral bus
  localparam logic [4:0] SM_CTRL   = 5'h00;
  localparam logic [4:0] SM_DUTY   = 5'h04;
  localparam logic [4:0] SM_TEMP   = 5'h08;
  localparam logic [4:0] SM_T_LO   = 5'h0C;
  localparam logic [4:0] SM_T_HI   = 5'h10;
  localparam logic [4:0] SM_TMAX   = 5'h14;
  localparam logic [4:0] SM_STATUS = 5'h18;

  // ADC channel carrying the on-die temperature sensor
  localparam logic [5:0] TEMP_CH = 6'd0;

  // Threshold values after reset
  localparam logic [15:0] T_LO_RST = 16'h9800;
  localparam logic [15:0] T_HI_RST = 16'hA000;

  // Fan controller state; the encoding is visible in STATUS[2:0]
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MANUAL = 3'd1,
    ST_QUIET  = 3'd2,
    ST_HOT    = 3'd3,
    ST_FAULT  = 3'd4
  } fan_state_t;

  // Replace only the byte lanes that are enabled
  function automatic logic [15:0] merge16(input logic [15:0] oldVal,
                                         input logic [15:0] newVal,
                                         input logic [1:0]  lanes);
    logic [15:0] result;
    result = oldVal;
    if (lanes[0]) result[7:0]  = newVal[7:0];
    if (lanes[1]) result[15:8] = newVal[15:8];
    return result;
  endfunction

  // Move one LSB toward the target, or hold when already there
  function automatic logic [7:0] stepToward(input logic [7:0] cur,
                                            input logic [7:0] tgt);
    logic [7:0] result;
    result = cur;
    if (cur < tgt)      result = cur + 8'd1;
    else if (cur > tgt) result = cur - 8'd1;
    return result;
  endfunction

endpackage

// File: rtl/fan_pwm.sv
// fan_pwm: prescaled 8-bit PWM generator. The counter advances once every
// PWM_DIV clocks; o_wrap pulses on the clock where it rolls 255 -> 0 so the
// controller can slew the duty once per PWM period.
module fan_pwm
  #(parameter int PWM_DIV = 40)
  (
    input  logic       cclk,
    input  logic       xreset,
    input  logic [7:0] i_duty,
    output logic       o_wrap,
    output logic       o_pwm
  );

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_cnt;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(PWM_DIV - 1));

  // Prescaler: divides the bus clock down to the PWM tick rate
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // 8-bit PWM counter, free running, advances on each tick
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)     r_cnt <= 8'd0;
    else if (w_tick) r_cnt <= r_cnt + 8'd1;
  end

  assign o_wrap = w_tick && (r_cnt == 8'hFF);
  assign o_pwm  = (r_cnt < i_duty) || (i_duty == 8'hFF);

endmodule

// File: rtl/sysmon_fan_ctrl.sv
// sysmon_fan_ctrl: thermal fan controller. Filters the temperature channel of
// the sysmon EOC stream, tracks the peak, runs a hysteresis state machine and
// slews the fan PWM duty. Define SYSMON_FAN_WATCHDOG_EN to compile in the
// sample watchdog and the FAULT state.
module sysmon_fan_ctrl
  import sysmon_pkg::*;
  #(
    parameter int         PWM_DIV   = 40,
    parameter logic [7:0] DUTY_MIN  = 8'h40,
    parameter int         AVG_SHIFT = 2,
    parameter int         TIMEOUT   = 1_000_000
  )
  (
    input  logic        cclk,
    input  logic        xreset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        rdy,
    input  logic        eoc_in,
    input  logic [5:0]  channel_in,
    input  logic [15:0] ad_data,
    output logic        fan_out
  );

  // Control / configuration registers
  logic        r_en;
  logic        r_auto;
  logic        r_force;
  logic [7:0]  r_dutyMan;
  logic [15:0] r_tLo;
  logic [15:0] r_tHi;

  // Measurement state
  logic [15:0] r_temp;
  logic [15:0] r_tMax;
  logic [7:0]  r_count;
  logic        r_first;
  logic        r_armed;

  // Control state
  fan_state_t  r_state;
  fan_state_t  w_nextState;
  logic [7:0]  r_applied;
  logic [7:0]  w_target;
  logic [31:0] r_dr;
  logic [31:0] w_rdata;

  logic               w_wr;
  logic               w_rd;
  logic               w_wrCtrl;
  logic               w_clrMax;
  logic               w_sample;
  logic signed [16:0] w_diff;
  logic signed [16:0] w_delta;
  logic               w_thrMove;
  logic               w_wdExpire;
  logic               w_wrap;
  logic               w_pwm;
  logic               w_unused;

  assign w_wr     = cs && (we != 4'b0000);
  assign w_rd     = cs && re;
  assign w_wrCtrl = w_wr && (adr == SM_CTRL) && we[0];
  assign w_clrMax = w_wrCtrl && dw[2];
  assign w_sample = eoc_in && (channel_in == TEMP_CH);

  // 17-bit signed error so a full-scale drop still shifts arithmetically
  assign w_diff  = $signed({1'b0, ad_data}) - $signed({1'b0, r_temp});
  assign w_delta = w_diff >>> AVG_SHIFT;

  assign w_unused = ^{dw[31:16], we[3:2]};

  // CTRL bits; CLR_MAX is a pulse and is never stored
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_force <= 1'b0;
    end else if (w_wrCtrl) begin
      r_en    <= dw[0];
      r_auto  <= dw[1];
      r_force <= dw[7];
    end
  end

  // Manual duty and thresholds, byte-lane writable
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      r_dutyMan <= 8'd0;
      r_tLo     <= T_LO_RST;
      r_tHi     <= T_HI_RST;
    end else if (w_wr) begin
      if (adr == SM_DUTY && we[0]) r_dutyMan <= dw[7:0];
      if (adr == SM_T_LO)          r_tLo     <= merge16(r_tLo, dw[15:0], we[1:0]);
      if (adr == SM_T_HI)          r_tHi     <= merge16(r_tHi, dw[15:0], we[1:0]);
    end
  end

  // Next sample seeds the filter after reset or whenever EN is switched on
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)                         r_first <= 1'b1;
    else if (w_wrCtrl && dw[0] && !r_en) r_first <= 1'b1;
    else if (w_sample)                   r_first <= 1'b0;
  end

  // Exponential filter, peak tracker and sample counter
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      r_temp  <= 16'd0;
      r_tMax  <= 16'd0;
      r_count <= 8'd0;
    end else begin
      if (w_sample) begin
        r_temp  <= r_first ? ad_data : (r_temp + w_delta[15:0]);
        r_count <= r_count + 8'd1;
        if (w_clrMax || (ad_data > r_tMax)) r_tMax <= ad_data;
      end else if (w_clrMax) begin
        r_tMax <= 16'd0;
      end
    end
  end

  // Each sample allows one threshold crossing, so overlapping thresholds
  // cannot make QUIET/HOT toggle every clock
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)        r_armed <= 1'b0;
    else if (w_sample)  r_armed <= 1'b1;
    else if (w_thrMove) r_armed <= 1'b0;
  end

  assign w_thrMove = ((r_state == ST_QUIET) && (w_nextState == ST_HOT)) ||
                     ((r_state == ST_HOT)   && (w_nextState == ST_QUIET));

`ifdef SYSMON_FAN_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wdActive;

  assign w_wdActive = (r_state == ST_QUIET) || (r_state == ST_HOT);
  assign w_wdExpire = w_wdActive && !w_sample && (r_wdog == WD_W'(TIMEOUT - 1));

  // Watchdog: counts clocks since the last temperature sample while regulating
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)                        r_wdog <= '0;
    else if (w_sample || !w_wdActive)   r_wdog <= '0;
    else if (r_wdog != WD_W'(TIMEOUT))  r_wdog <= r_wdog + 1'b1;
  end
`else
  logic w_unused_timeout;

  assign w_wdExpire       = 1'b0;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // Next-state logic for the hysteresis controller
  always_comb begin
    w_nextState = r_state;
    if (!r_en) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_nextState = r_auto ? ST_QUIET : ST_MANUAL;
        ST_MANUAL: if (r_auto) w_nextState = ST_QUIET;
        ST_QUIET: begin
          if (!r_auto)                          w_nextState = ST_MANUAL;
          else if (w_wdExpire)                  w_nextState = ST_FAULT;
          else if (r_armed && (r_temp >= r_tHi)) w_nextState = ST_HOT;
        end
        ST_HOT: begin
          if (!r_auto)                          w_nextState = ST_MANUAL;
          else if (w_wdExpire)                  w_nextState = ST_FAULT;
          else if (r_armed && (r_temp < r_tLo))  w_nextState = ST_QUIET;
        end
        ST_FAULT:  if (w_sample) w_nextState = ST_QUIET;
        default:   w_nextState = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  // Duty the current state asks for
  always_comb begin
    w_target = 8'd0;
    case (r_state)
      ST_IDLE:   w_target = 8'd0;
      ST_MANUAL: w_target = r_dutyMan;
      ST_QUIET:  w_target = DUTY_MIN;
      ST_HOT:    w_target = 8'hFF;
      ST_FAULT:  w_target = 8'hFF;
      default:   w_target = 8'd0;
    endcase
  end

  // Applied duty: FORCE and IDLE act at once, otherwise slew once per period
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)                 r_applied <= 8'd0;
    else if (r_force)            r_applied <= 8'hFF;
    else if (r_state == ST_IDLE) r_applied <= 8'd0;
    else if (w_wrap)             r_applied <= stepToward(r_applied, w_target);
  end

  // Read data selection
  always_comb begin
    w_rdata = 32'd0;
    case (adr)
      SM_CTRL:   w_rdata = {24'd0, r_force, 4'd0, 1'b0, r_auto, r_en};
      SM_DUTY:   w_rdata = {24'd0, r_applied};
      SM_TEMP:   w_rdata = {16'd0, r_temp};
      SM_T_LO:   w_rdata = {16'd0, r_tLo};
      SM_T_HI:   w_rdata = {16'd0, r_tHi};
      SM_TMAX:   w_rdata = {16'd0, r_tMax};
      SM_STATUS: w_rdata = {16'd0, r_count, 5'd0, r_state};
      default:   w_rdata = 32'd0;
    endcase
  end

  // Registered read port, holds until the next read strobe
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset)   r_dr <= 32'd0;
    else if (w_rd) r_dr <= w_rdata;
  end

  fan_pwm #(.PWM_DIV(PWM_DIV)) u_pwm (
    .cclk   (cclk),
    .xreset (xreset),
    .i_duty (r_applied),
    .o_wrap (w_wrap),
    .o_pwm  (w_pwm)
  );

  assign dr      = r_dr;
  assign rdy     = 1'b1;
  assign fan_out = w_pwm;

endmodule
